usb_txn_ctrl: RTL
=================

# usb_txn_ctrl

Transaction-level protocol controller for the USB host. It accepts one OUT or IN request from the host task layer and sequences the packet encoder (sync/PID/token/data/CRC/stuff/NRZI/EOP) and the packet decoder through the full token, data and handshake exchange. Failed attempts are retried with a response timeout. It sits between the host-side read/write request logic and the bit-level tx/rx datapath.

## Interface
- `TIMEOUT_CYCLES`, default 255: clk cycles to wait for a device response before declaring a timeout.
- `MAX_RETRIES`, default 8: total attempts allowed before reporting failure.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_L`  in  1  reset, synchronous, active-low.
- `txn_start`  in  1  one-cycle request pulse; sampled only in IDLE.
- `txn_is_in`  in  1  1 = IN transaction, 0 = OUT.
- `txn_addr`  in  7  device address.
- `txn_endp`  in  4  endpoint.
- `txn_wdata`  in  64  OUT payload.
- `txn_busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `txn_done`  out  1  one-cycle completion pulse.
- `txn_ok`  out  1  valid with `txn_done`; 1 = ACKed (OUT) or good data received (IN).
- `txn_rdata`  out  64  IN payload; updates only on a successful IN.
- `enc_start`  out  1  one-cycle pulse that launches one packet in the encoder.
- `enc_pid`  out  4  PID[3:0]; the encoder appends the complement nibble.
- `enc_addr`  out  7  token address field.
- `enc_endp`  out  4  token endpoint field.
- `enc_data`  out  64  DATA packet payload.
- `enc_done`  in  1  one-cycle pulse when the encoder finishes EOP.
- `dec_en`  out  1  receiver enable.
- `dec_valid`  in  1  one-cycle pulse when a packet is received.
- `dec_pid`  in  4  received PID[3:0].
- `dec_data`  in  64  received payload.
- `dec_crc_ok`  in  1  CRC and PID check passed; valid with `dec_valid`.

## Operation
- PIDs: OUT=4'b0001, IN=4'b1001, DATA0=4'b0011, ACK=4'b0010, NAK=4'b1010.
- IDLE: when `txn_start`=1, latch dir, addr, endp and wdata, clear the attempt count, and go to TOKEN.
- TOKEN: pulse `enc_start` with PID OUT or IN. Go to TOKEN_WAIT. On `enc_done`, go to DATA_TX if OUT, or to RX_WAIT if IN.
- DATA_TX (OUT): pulse `enc_start` with PID DATA0 and `enc_data`=wdata. On `enc_done`, go to HS_WAIT.
- HS_WAIT: `dec_en`=1 and the timer runs.
  - `dec_valid` with `dec_crc_ok`=1 and PID ACK: go to DONE with ok=1.
  - NAK, any other PID, crc fail, or timeout: go to FAIL.
- RX_WAIT (IN): `dec_en`=1 and the timer runs.
  - `dec_valid` with `dec_crc_ok`=1 and PID DATA0: capture `dec_data` into `txn_rdata` and go to ACK_TX.
  - Anything else, or timeout: go to FAIL. No handshake is sent on a bad packet.
- ACK_TX: pulse `enc_start` with PID ACK. On `enc_done`, go to DONE with ok=1.
- FAIL: increment the attempt count.
  - If the count equals `MAX_RETRIES`, go to DONE with ok=0.
  - Otherwise go back to TOKEN, which resends the full transaction.
- DONE: `txn_done`=1 for one cycle, then IDLE.
- `enc_pid`, `enc_addr`, `enc_endp` and `enc_data` stay stable from `enc_start` until `enc_done`.
- `dec_valid` outside HS_WAIT or RX_WAIT is ignored.
- `txn_start` while busy is ignored.

## Timing
- Reset values: all outputs 0, `txn_rdata`=0, state IDLE, counters 0. Reset mid-transaction returns to IDLE on the next edge with no `txn_done`.
- Start latency: `txn_start` at edge N gives `enc_start` high in cycle N+1.
- `enc_done` or `dec_valid` at edge N gives the next state's action (for example `enc_start`) in cycle N+1.
- Timer: clears on entry to a wait state and increments each cycle there. Timeout fires when the count equals `TIMEOUT_CYCLES`.
  - Width is $clog2(TIMEOUT_CYCLES+1); the timer saturates and never wraps.
- If `dec_valid` and timeout occur in the same cycle, `dec_valid` wins.
- Attempt counter width is $clog2(MAX_RETRIES+1). FAIL lasts exactly one cycle.
- The DONE cycle sets `txn_ok` and `txn_done` together.
- Cycle after DONE: the block is in IDLE and accepts a new `txn_start`.

## Structure
- Shared package `usb_pkg`:
  - `pid_t` enum holding the PID constants above.
  - `txn_state_t` enum: IDLE, TOKEN, TOKEN_WAIT, DATA_TX, DATA_WAIT, HS_WAIT, RX_WAIT, ACK_TX, ACK_WAIT, FAIL, DONE.
  - Default timeout and retry constants.
- One sub-module, `usb_txn_timer`: contains the response timer and the attempt counter, with clear, enable and increment controls and `timeout`/`exhausted` flags.
- The FSM lives in `usb_txn_ctrl`.

## Test plan
- OUT, addr 7'h05, endp 4'h4, wdata 64'hDEADBEEF_CAFEF00D; device ACKs.
  - Expect `enc_pid` OUT then DATA0 with the data unchanged, then `txn_done`=1, `txn_ok`=1, and one attempt.
- IN, addr 5, endp 8; device returns good DATA0 64'h0123456789ABCDEF.
  - Expect ACK sent, `txn_rdata` equal to that payload, `txn_ok`=1.
- OUT; device NAKs twice then ACKs.
  - Expect exactly 3 OUT tokens, `txn_ok`=1.
- IN with no device response, default parameters.
  - Expect 8 attempts, each wait lasting 255 cycles, then `txn_ok`=0 and `txn_rdata` still 0.
- IN with `dec_crc_ok`=0 on the first data packet, good on the second.
  - Expect no ACK after the first packet, a retry, then ACK and `txn_ok`=1.
- Two edge cases:
  - `rst_L`=0 during DATA_WAIT: expect all outputs 0 the next cycle and no `txn_done`.
  - `txn_start` pulsed while busy: expect it ignored.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB host transaction controller.
package usb_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 7;
    localparam int ENDP_W = 4;
    localparam int PID_W  = 4;

    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_MAX_RETRIES    = 8;

    // Low nibble of each PID; the encoder appends the complement nibble.
    typedef enum logic [PID_W-1:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    typedef enum logic [3:0] {
        IDLE,
        TOKEN,
        TOKEN_WAIT,
        DATA_TX,
        DATA_WAIT,
        HS_WAIT,
        RX_WAIT,
        ACK_TX,
        ACK_WAIT,
        FAIL,
        DONE
    } txn_state_t;

    // Token PID for the requested transfer direction.
    function automatic logic [PID_W-1:0] token_pid(input logic is_in);
        return is_in ? PID_IN : PID_OUT;
    endfunction

endpackage

// File: rtl/usb_txn_ctrl_if.sv
// Host request bus plus encoder/decoder handshake of the transaction controller.
// The slave modport is the controller; master is the host and tx/rx datapath side.
interface usb_txn_ctrl_if;
    import usb_pkg::*;

    logic              txn_start;
    logic              txn_is_in;
    logic [ADDR_W-1:0] txn_addr;
    logic [ENDP_W-1:0] txn_endp;
    logic [DATA_W-1:0] txn_wdata;
    logic              txn_busy;
    logic              txn_done;
    logic              txn_ok;
    logic [DATA_W-1:0] txn_rdata;

    logic              enc_start;
    logic [PID_W-1:0]  enc_pid;
    logic [ADDR_W-1:0] enc_addr;
    logic [ENDP_W-1:0] enc_endp;
    logic [DATA_W-1:0] enc_data;
    logic              enc_done;

    logic              dec_en;
    logic              dec_valid;
    logic [PID_W-1:0]  dec_pid;
    logic [DATA_W-1:0] dec_data;
    logic              dec_crc_ok;

    modport slave (
        input  txn_start, txn_is_in, txn_addr, txn_endp, txn_wdata,
        output txn_busy, txn_done, txn_ok, txn_rdata,
        output enc_start, enc_pid, enc_addr, enc_endp, enc_data,
        input  enc_done,
        output dec_en,
        input  dec_valid, dec_pid, dec_data, dec_crc_ok
    );

    modport master (
        output txn_start, txn_is_in, txn_addr, txn_endp, txn_wdata,
        input  txn_busy, txn_done, txn_ok, txn_rdata,
        input  enc_start, enc_pid, enc_addr, enc_endp, enc_data,
        output enc_done,
        input  dec_en,
        output dec_valid, dec_pid, dec_data, dec_crc_ok
    );

endinterface

// File: rtl/usb_txn_timer.sv
// Response timer and attempt counter for the transaction controller.
// Both saturate; timeout/exhausted are decoded straight from the counts.
module usb_txn_timer
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic clk,
    input  logic rst_L,
    input  logic tmr_clr,
    input  logic tmr_en,
    input  logic att_clr,
    input  logic att_inc,
    output logic timeout,
    output logic exhausted
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_RETRIES);
    // The attempt being failed is the last one allowed when the count
    // still reads one below the limit (the increment lands on the limit).
    localparam logic [AW-1:0] ATT_LAST = AW'(MAX_RETRIES - 1);

    logic [TW-1:0] tmr_cnt;
    logic [AW-1:0] att_cnt;

    // Response timer: cleared outside the wait states, counts up and holds at the limit.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            tmr_cnt <= '0;
        end else if (tmr_clr) begin
            tmr_cnt <= '0;
        end else if (tmr_en && (tmr_cnt != TMR_MAX)) begin
            tmr_cnt <= tmr_cnt + 1'b1;
        end
    end

    // Attempt counter: cleared when a request is accepted, bumped once per failed try.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            att_cnt <= '0;
        end else if (att_clr) begin
            att_cnt <= '0;
        end else if (att_inc && (att_cnt != ATT_MAX)) begin
            att_cnt <= att_cnt + 1'b1;
        end
    end

    assign timeout   = (tmr_cnt == TMR_MAX);
    assign exhausted = (att_cnt == ATT_LAST);

endmodule

// File: rtl/usb_txn_ctrl.sv
// USB host transaction controller: sequences token, data and handshake
// packets through the encoder/decoder, retrying failed attempts.
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic          clk,
    input  logic          rst_L,
    usb_txn_ctrl_if.slave bus
);

    txn_state_t        state;
    txn_state_t        state_nxt;

    logic              is_in_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ENDP_W-1:0] endp_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ok_q;
    logic              ok_nxt;

    logic              latch_req;
    logic              rdata_cap;
    logic              att_clr;
    logic              att_inc;
    logic              tmr_en;
    logic              tmr_clr;
    logic              timeout;
    logic              exhausted;

    logic              good_ack;
    logic              good_data;
    logic              enc_start_c;
    logic [PID_W-1:0]  enc_pid_c;

    assign good_ack  = bus.dec_crc_ok && (bus.dec_pid == PID_ACK);
    assign good_data = bus.dec_crc_ok && (bus.dec_pid == PID_DATA0);

    // The timer only runs while the receiver is listening; any other state holds it clear.
    assign tmr_en  = (state == HS_WAIT) || (state == RX_WAIT);
    assign tmr_clr = !tmr_en;

    usb_txn_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_timer (
        .clk       (clk),
        .rst_L     (rst_L),
        .tmr_clr   (tmr_clr),
        .tmr_en    (tmr_en),
        .att_clr   (att_clr),
        .att_inc   (att_inc),
        .timeout   (timeout),
        .exhausted (exhausted)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, received payload and completion status.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            is_in_q <= 1'b0;
            addr_q  <= '0;
            endp_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ok_q    <= 1'b0;
        end else begin
            if (latch_req) begin
                is_in_q <= bus.txn_is_in;
                addr_q  <= bus.txn_addr;
                endp_q  <= bus.txn_endp;
                wdata_q <= bus.txn_wdata;
            end
            if (rdata_cap) begin
                rdata_q <= bus.dec_data;
            end
            ok_q <= ok_nxt;
        end
    end

    // Next-state logic; dec_valid is checked before timeout so a late packet still counts.
    always_comb begin
        state_nxt = state;
        ok_nxt    = ok_q;
        latch_req = 1'b0;
        rdata_cap = 1'b0;
        att_clr   = 1'b0;
        att_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.txn_start) begin
                    latch_req = 1'b1;
                    att_clr   = 1'b1;
                    ok_nxt    = 1'b0;
                    state_nxt = TOKEN;
                end
            end
            TOKEN:      state_nxt = TOKEN_WAIT;
            TOKEN_WAIT: begin
                if (bus.enc_done) begin
                    state_nxt = is_in_q ? RX_WAIT : DATA_TX;
                end
            end
            DATA_TX:    state_nxt = DATA_WAIT;
            DATA_WAIT: begin
                if (bus.enc_done) begin
                    state_nxt = HS_WAIT;
                end
            end
            HS_WAIT: begin
                if (bus.dec_valid) begin
                    if (good_ack) begin
                        ok_nxt    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FAIL;
                    end
                end else if (timeout) begin
                    state_nxt = FAIL;
                end
            end
            RX_WAIT: begin
                if (bus.dec_valid) begin
                    if (good_data) begin
                        rdata_cap = 1'b1;
                        state_nxt = ACK_TX;
                    end else begin
                        state_nxt = FAIL;
                    end
                end else if (timeout) begin
                    state_nxt = FAIL;
                end
            end
            ACK_TX:     state_nxt = ACK_WAIT;
            ACK_WAIT: begin
                if (bus.enc_done) begin
                    ok_nxt    = 1'b1;
                    state_nxt = DONE;
                end
            end
            FAIL: begin
                att_inc = 1'b1;
                if (exhausted) begin
                    ok_nxt    = 1'b0;
                    state_nxt = DONE;
                end else begin
                    state_nxt = TOKEN;
                end
            end
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Encoder drive: PID is decoded from state so it holds from launch through the wait.
    always_comb begin
        enc_start_c = 1'b0;
        enc_pid_c   = '0;
        case (state)
            TOKEN: begin
                enc_start_c = 1'b1;
                enc_pid_c   = token_pid(is_in_q);
            end
            TOKEN_WAIT: enc_pid_c = token_pid(is_in_q);
            DATA_TX: begin
                enc_start_c = 1'b1;
                enc_pid_c   = PID_DATA0;
            end
            DATA_WAIT:  enc_pid_c = PID_DATA0;
            ACK_TX: begin
                enc_start_c = 1'b1;
                enc_pid_c   = PID_ACK;
            end
            ACK_WAIT:   enc_pid_c = PID_ACK;
            default: begin
                enc_start_c = 1'b0;
                enc_pid_c   = '0;
            end
        endcase
    end

    assign bus.enc_start = enc_start_c;
    assign bus.enc_pid   = enc_pid_c;
    assign bus.enc_addr  = addr_q;
    assign bus.enc_endp  = endp_q;
    assign bus.enc_data  = wdata_q;
    assign bus.dec_en    = tmr_en;

    assign bus.txn_busy  = (state != IDLE);
    assign bus.txn_done  = (state == DONE);
    assign bus.txn_ok    = (state == DONE) && ok_q;
    assign bus.txn_rdata = rdata_q;

endmodule
